// File: rtl/stack_pkg.sv
// Shared types and defaults for the two-requester arbitrated stack.
// Holds the operation encoding, the FSM state type and the size defaults.
// Also provides the round-robin pick used when latching a request.
package stack_pkg;

  localparam int DEF_DEPTH = 16;
  localparam int DEF_WIDTH = 8;

  // Requester operation encoding as seen on op0/op1.
  typedef enum logic [1:0] {
    OP_PUSH = 2'b00,
    OP_POP  = 2'b01,
    OP_PEEK = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  // Arbiter sequencer: accept, execute, respond.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // Returns the index of the winning requester. A lone requester wins;
  // on a tie the requester that was not served last wins.
  function automatic logic rr_pick(input logic req0, input logic req1,
                                   input logic last_served);
    if (req0 && req1) begin
      return ~last_served;
    end
    return req1;
  endfunction

endpackage

// File: rtl/stack_mem.sv
// Stack storage: DEPTH x WIDTH array, one synchronous write port.
// Latency: write lands at the clock edge; read port is combinational.
// Backpressure: none; the caller guarantees addresses are in range.
module stack_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Write the pushed entry at the current top-of-stack slot.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/stack_arbiter.sv
// Two-requester round-robin arbiter in front of a push/pop stack.
// Latency: done pulses 2 edges after req is sampled; one op every 3 cycles.
// Backpressure: requests are only accepted in IDLE (busy low); none queued.
// Optional feature: define STACK_ARB_PEEK_EN to enable the peek op (10).
module stack_arbiter
  import stack_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0,
  input  logic                   req1,
  input  logic [1:0]             op0,
  input  logic [1:0]             op1,
  input  logic [WIDTH-1:0]       wdata0,
  input  logic [WIDTH-1:0]       wdata1,
  output logic                   done0,
  output logic                   done1,
  output logic [WIDTH-1:0]       rdata,
  output logic                   err,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e           r_state;
  logic [LW-1:0]    r_sp;
  logic             r_last;
  logic             r_win;
  op_e              r_op;
  logic [WIDTH-1:0] r_wdata;
  logic             r_done0;
  logic             r_done1;
  logic             r_err;
  logic [WIDTH-1:0] r_rdata;

  logic             w_full;
  logic             w_empty;
  logic             w_win;
  logic             w_we;
  logic [AW-1:0]    w_waddr;
  logic [AW-1:0]    w_raddr;
  logic [WIDTH-1:0] w_rd_dat;

  // Occupancy flags are derived straight from the registered pointer.
  assign w_full  = (r_sp == LW'(DEPTH));
  assign w_empty = (r_sp == '0);
  assign w_win   = rr_pick(req0, req1, r_last);

  // Only a successful push in EXEC writes; address is the current top slot.
  assign w_we    = (r_state == ST_EXEC) && (r_op == OP_PUSH) && !w_full;
  assign w_waddr = AW'(r_sp);
  assign w_raddr = AW'(r_sp - LW'(1));

  stack_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (r_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_rd_dat)
  );

  // Sequencer: latch the winner in IDLE, execute in EXEC, pulse done in RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_sp    <= '0;
      r_last  <= 1'b1;
      r_win   <= 1'b0;
      r_op    <= OP_PUSH;
      r_wdata <= '0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done0 <= 1'b0;
          r_done1 <= 1'b0;
          if (req0 || req1) begin
            r_win   <= w_win;
            r_last  <= w_win;
            r_op    <= w_win ? op_e'(op1) : op_e'(op0);
            r_wdata <= w_win ? wdata1 : wdata0;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_state <= ST_RESP;
          r_done0 <= ~r_win;
          r_done1 <= r_win;
          r_err   <= 1'b0;
          r_rdata <= '0;
          case (r_op)
            OP_PUSH: begin
              if (w_full) begin
                r_err <= 1'b1;
              end else begin
                r_sp <= r_sp + LW'(1);
              end
            end
            OP_POP: begin
              if (w_empty) begin
                r_err <= 1'b1;
              end else begin
                r_rdata <= w_rd_dat;
                r_sp    <= r_sp - LW'(1);
              end
            end
`ifdef STACK_ARB_PEEK_EN
            OP_PEEK: begin
              if (w_empty) begin
                r_err <= 1'b1;
              end else begin
                r_rdata <= w_rd_dat;
              end
            end
`endif
            default: begin
              // Reserved encodings (and peek when it is compiled out).
              r_err <= 1'b1;
            end
          endcase
        end
        ST_RESP: begin
          r_done0 <= 1'b0;
          r_done1 <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign done0 = r_done0;
  assign done1 = r_done1;
  assign err   = r_err;
  assign rdata = r_rdata;
  assign full  = w_full;
  assign empty = w_empty;
  assign level = r_sp;
  assign busy  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_stack_arbiter.sv
// Directed self-checking bench for stack_arbiter (DEPTH=16, WIDTH=8).
// Inputs change and outputs are sampled 1ns after the rising edge.
// Peek expectations follow the STACK_ARB_PEEK_EN macro.
module tb_stack_arbiter;

  localparam logic [1:0] P_PUSH = 2'b00;
  localparam logic [1:0] P_POP  = 2'b01;
  localparam logic [1:0] P_PEEK = 2'b10;
  localparam logic [1:0] P_RSVD = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [1:0] op0 = 2'b00, op1 = 2'b00;
  logic [7:0] wdata0 = 8'h00, wdata1 = 8'h00;
  logic       done0, done1, err, full, empty, busy;
  logic [7:0] rdata;
  logic [4:0] level;

  int n_cmp = 0;
  int n_bad = 0;

  stack_arbiter #(.DEPTH(16), .WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .wdata0(wdata0), .wdata1(wdata1),
    .done0(done0), .done1(done1), .rdata(rdata), .err(err),
    .full(full), .empty(empty), .level(level), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // Issue one operation from one requester and wait (bounded) for its done.
  // Returns with the arbiter back in IDLE.
  task automatic op_single(input int who, input logic [1:0] op, input logic [7:0] d,
                           output logic got, output logic e, output logic [7:0] rd,
                           output int lat);
    got = 1'b0; e = 1'b0; rd = 8'h00; lat = 0;
    if (who == 0) begin req0 = 1'b1; op0 = op; wdata0 = d; end
    else begin req1 = 1'b1; op1 = op; wdata1 = d; end
    for (int n = 1; n <= 8; n++) begin
      tick();
      if ((who == 0 && done0) || (who == 1 && done1)) begin
        got = 1'b1; e = err; rd = rdata; lat = n;
        break;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty got %b want 1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL reset_full got %b want 0", full); end
    n_cmp++; if (level !== 5'd0) begin n_bad++; $display("FAIL reset_level got %0d want 0", level); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if ({done0, done1, err} !== 3'b000) begin n_bad++; $display("FAIL reset_done_err got %b want 000", {done0, done1, err}); end
    n_cmp++; if (rdata !== 8'h00) begin n_bad++; $display("FAIL reset_rdata got %h want 00", rdata); end
  endtask

  task automatic test_push_basic();
    logic g, e; logic [7:0] rd; int lat;
    do_reset();
    req0 = 1'b1; op0 = P_PUSH; wdata0 = 8'hA5;
    tick();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL push_busy_exec got %b want 1", busy); end
    n_cmp++; if (done0 !== 1'b0) begin n_bad++; $display("FAIL push_done_early got %b want 0", done0); end
    tick();
    g = done0; e = err; lat = 2;
    n_cmp++; if (g !== 1'b1) begin n_bad++; $display("FAIL push_done_lat2 got %b want 1", g); end
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL push_err got %b want 0", e); end
    n_cmp++; if (done1 !== 1'b0) begin n_bad++; $display("FAIL push_done1 got %b want 0", done1); end
    req0 = 1'b0;
    tick();
    n_cmp++; if (done0 !== 1'b0) begin n_bad++; $display("FAIL push_done_width got %b want 0", done0); end
    n_cmp++; if ({level, empty, busy} !== {5'd1, 1'b0, 1'b0}) begin n_bad++; $display("FAIL push_status got lvl=%0d empty=%b busy=%b want 1 0 0", level, empty, busy); end
    op_single(0, P_PUSH, 8'h5A, g, e, rd, lat);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL push_latency got %0d want 2", lat); end
  endtask

  task automatic test_push_pop();
    logic g, e; logic [7:0] rd; int lat;
    do_reset();
    op_single(0, P_PUSH, 8'h11, g, e, rd, lat);
    op_single(1, P_POP, 8'h00, g, e, rd, lat);
    n_cmp++; if ({g, e} !== 2'b10) begin n_bad++; $display("FAIL pop_done_err got %b want 10", {g, e}); end
    n_cmp++; if (rd !== 8'h11) begin n_bad++; $display("FAIL pop_rdata got %h want 11", rd); end
    n_cmp++; if (level !== 5'd0) begin n_bad++; $display("FAIL pop_level got %0d want 0", level); end
  endtask

  task automatic test_round_robin();
    logic g, e; logic [7:0] rd; int lat; int t0, t1; logic both;
    do_reset();
    t0 = 0; t1 = 0; both = 1'b0;
    req0 = 1'b1; op0 = P_PUSH; wdata0 = 8'h01;
    req1 = 1'b1; op1 = P_PUSH; wdata1 = 8'h02;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (done0 && done1) both = 1'b1;
      if (done0 && t0 == 0) begin t0 = n; req0 = 1'b0; end
      if (done1 && t1 == 0) begin t1 = n; req1 = 1'b0; end
    end
    req0 = 1'b0; req1 = 1'b0;
    n_cmp++; if (t0 !== 2) begin n_bad++; $display("FAIL rr_req0_time got %0d want 2", t0); end
    n_cmp++; if (t1 !== 5) begin n_bad++; $display("FAIL rr_req1_time got %0d want 5", t1); end
    n_cmp++; if (both !== 1'b0) begin n_bad++; $display("FAIL rr_both_done got %b want 0", both); end
    n_cmp++; if (level !== 5'd2) begin n_bad++; $display("FAIL rr_level got %0d want 2", level); end
    op_single(0, P_POP, 8'h00, g, e, rd, lat);
    n_cmp++; if ({g, e, rd} !== {2'b10, 8'h02}) begin n_bad++; $display("FAIL rr_pop1 got g=%b e=%b rd=%h want 1 0 02", g, e, rd); end
    op_single(0, P_POP, 8'h00, g, e, rd, lat);
    n_cmp++; if ({g, e, rd} !== {2'b10, 8'h01}) begin n_bad++; $display("FAIL rr_pop2 got g=%b e=%b rd=%h want 1 0 01", g, e, rd); end
  endtask

  // After req0 alone was served, a tie must go to req1.
  task automatic test_rr_after_req0();
    logic g, e; logic [7:0] rd; int lat; int t0, t1; logic e0, e1; logic [7:0] r0, r1;
    do_reset();
    op_single(0, P_PUSH, 8'h10, g, e, rd, lat);
    t0 = 0; t1 = 0; e0 = 1'b0; e1 = 1'b0; r0 = 8'hFF; r1 = 8'hFF;
    req0 = 1'b1; op0 = P_POP; req1 = 1'b1; op1 = P_POP;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (done0 && t0 == 0) begin t0 = n; e0 = err; r0 = rdata; req0 = 1'b0; end
      if (done1 && t1 == 0) begin t1 = n; e1 = err; r1 = rdata; req1 = 1'b0; end
    end
    req0 = 1'b0; req1 = 1'b0;
    n_cmp++; if ({t1, t0} !== {32'd2, 32'd5}) begin n_bad++; $display("FAIL rr2_order got t1=%0d t0=%0d want 2 5", t1, t0); end
    n_cmp++; if ({e1, r1} !== {1'b0, 8'h10}) begin n_bad++; $display("FAIL rr2_req1_pop got e=%b rd=%h want 0 10", e1, r1); end
    n_cmp++; if ({e0, r0} !== {1'b1, 8'h00}) begin n_bad++; $display("FAIL rr2_req0_empty got e=%b rd=%h want 1 00", e0, r0); end
  endtask

  task automatic test_full_empty();
    logic g, e; logic [7:0] rd; int lat; int bad_push, bad_pop;
    do_reset();
    bad_push = 0; bad_pop = 0;
    for (int i = 0; i < 16; i++) begin
      op_single(i % 2, P_PUSH, 8'h20 + 8'(i), g, e, rd, lat);
      if (g !== 1'b1 || e !== 1'b0) bad_push++;
    end
    n_cmp++; if (bad_push !== 0) begin n_bad++; $display("FAIL fill_pushes got %0d bad want 0", bad_push); end
    n_cmp++; if ({full, level} !== {1'b1, 5'd16}) begin n_bad++; $display("FAIL fill_status got full=%b lvl=%0d want 1 16", full, level); end
    op_single(0, P_PUSH, 8'hEE, g, e, rd, lat);
    n_cmp++; if ({g, e} !== 2'b11) begin n_bad++; $display("FAIL overflow_err got %b want 11", {g, e}); end
    n_cmp++; if ({full, level} !== {1'b1, 5'd16}) begin n_bad++; $display("FAIL overflow_status got full=%b lvl=%0d want 1 16", full, level); end
    for (int i = 15; i >= 0; i--) begin
      op_single(1, P_POP, 8'h00, g, e, rd, lat);
      if (g !== 1'b1 || e !== 1'b0 || rd !== 8'h20 + 8'(i)) bad_pop++;
    end
    n_cmp++; if (bad_pop !== 0) begin n_bad++; $display("FAIL drain_lifo got %0d bad want 0", bad_pop); end
    op_single(0, P_POP, 8'h00, g, e, rd, lat);
    n_cmp++; if ({g, e, rd} !== {2'b11, 8'h00}) begin n_bad++; $display("FAIL underflow got g=%b e=%b rd=%h want 1 1 00", g, e, rd); end
    n_cmp++; if ({empty, level} !== {1'b1, 5'd0}) begin n_bad++; $display("FAIL underflow_status got empty=%b lvl=%0d want 1 0", empty, level); end
  endtask

  task automatic test_peek_rsvd();
    logic g, e; logic [7:0] rd; int lat;
    do_reset();
    op_single(0, P_PUSH, 8'h3C, g, e, rd, lat);
    op_single(1, P_PEEK, 8'h00, g, e, rd, lat);
`ifdef STACK_ARB_PEEK_EN
    n_cmp++; if ({g, e, rd} !== {2'b10, 8'h3C}) begin n_bad++; $display("FAIL peek got g=%b e=%b rd=%h want 1 0 3c", g, e, rd); end
`else
    n_cmp++; if ({g, e} !== 2'b11) begin n_bad++; $display("FAIL peek_disabled got g=%b e=%b want 1 1", g, e); end
`endif
    n_cmp++; if (level !== 5'd1) begin n_bad++; $display("FAIL peek_level got %0d want 1", level); end
    op_single(0, P_RSVD, 8'h99, g, e, rd, lat);
    n_cmp++; if ({g, e, level} !== {2'b11, 5'd1}) begin n_bad++; $display("FAIL rsvd got g=%b e=%b lvl=%0d want 1 1 1", g, e, level); end
    op_single(1, P_POP, 8'h00, g, e, rd, lat);
    n_cmp++; if ({g, e, rd} !== {2'b10, 8'h3C}) begin n_bad++; $display("FAIL peek_then_pop got g=%b e=%b rd=%h want 1 0 3c", g, e, rd); end
  endtask

  task automatic test_ignore_busy();
    logic seen1;
    do_reset();
    seen1 = 1'b0;
    req0 = 1'b1; op0 = P_PUSH; wdata0 = 8'h40;
    tick();
    req1 = 1'b1; op1 = P_PUSH; wdata1 = 8'h55;
    tick();
    req0 = 1'b0; req1 = 1'b0;
    for (int n = 0; n < 6; n++) begin
      tick();
      if (done1) seen1 = 1'b1;
    end
    n_cmp++; if ({seen1, level} !== {1'b0, 5'd1}) begin n_bad++; $display("FAIL ignore_busy got done1=%b lvl=%0d want 0 1", seen1, level); end
  endtask

  task automatic test_reset_abort();
    logic seen;
    do_reset();
    seen = 1'b0;
    req0 = 1'b1; op0 = P_PUSH; wdata0 = 8'h77;
    tick();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL abort_in_exec got busy=%b want 1", busy); end
    rst = 1'b1; req0 = 1'b0;
    tick();
    rst = 1'b0;
    n_cmp++; if ({done0, level, busy} !== {1'b0, 5'd0, 1'b0}) begin n_bad++; $display("FAIL abort_state got done0=%b lvl=%0d busy=%b want 0 0 0", done0, level, busy); end
    for (int n = 0; n < 4; n++) begin
      tick();
      if (done0 || done1) seen = 1'b1;
    end
    n_cmp++; if ({seen, empty} !== 2'b01) begin n_bad++; $display("FAIL abort_no_done got done=%b empty=%b want 0 1", seen, empty); end
  endtask

  initial begin
    test_reset();
    test_push_basic();
    test_push_pop();
    test_round_robin();
    test_rr_after_req0();
    test_full_empty();
    test_peek_rsvd();
    test_ignore_busy();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stack_arbiter.md
STACK_ARBITER -- requirements
Module: stack_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 16, stack entries.
REQ-002 SHALL have parameter WIDTH, default 8, data bits per entry.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on posedge clk.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have ports req0/req1, input, 1 each, requester operation request.
REQ-006 SHALL have ports op0/op1, input, 2 each, operation: 00 push, 01 pop, 10 peek, 11 reserved.
REQ-007 SHALL have ports wdata0/wdata1, input, WIDTH each, push data.
REQ-008 SHALL have ports done0/done1, output, 1 each, one-cycle completion pulse.
REQ-009 SHALL have port rdata, output, WIDTH, pop/peek result; valid only while a done is high and err is low.
REQ-010 SHALL have port err, output, 1, failed operation; valid only while a done is high.
REQ-011 SHALL have ports full, empty, output, 1 each, and level, output, $clog2(DEPTH)+1, occupancy.
REQ-012 SHALL have port busy, output, 1, high whenever the FSM is not IDLE.

Function
REQ-013 FSM SHALL have states IDLE, EXEC and RESP; transitions are IDLE->EXEC on any req, EXEC->RESP unconditionally, and RESP->IDLE unconditionally.
REQ-014 In IDLE with any req high, the FSM SHALL latch the winner index, its op and its wdata at the clock edge.
REQ-015 Arbitration SHALL be round-robin: a lone requester wins; if both request, the requester not served last wins.
REQ-016 In EXEC, a push with level<DEPTH SHALL write mem[sp] and increment sp.
REQ-017 In EXEC, a pop with level>0 SHALL capture mem[sp-1] into rdata and decrement sp.
REQ-018 In EXEC, a peek with level>0 SHALL capture mem[sp-1] into rdata; sp is unchanged.
REQ-019 In RESP, the FSM SHALL assert done of the winner only, for exactly one cycle, with err and rdata valid.
REQ-020 Latency: done SHALL be high 2 cycles after the edge that sampled req; one operation completes per 3 cycles.
REQ-021 A push when full SHALL set err=1 without a write; sp is unchanged.
REQ-022 A pop or peek when empty SHALL set err=1 and rdata=0; sp is unchanged.
REQ-023 Op 11 SHALL set err=1 with no state change.
REQ-024 A requester SHALL hold req, op and wdata stable until it samples its done, then drop req at that edge unless it issues a new operation.
REQ-025 Inputs SHALL be ignored outside IDLE; the arbiter does not queue requests.
REQ-026 full SHALL equal (level==DEPTH), empty SHALL equal (level==0), and level SHALL equal sp; all three are combinational from the registered sp.
REQ-027 sp SHALL never wrap; it is bounded 0..DEPTH by REQ-021/022.

Reset
REQ-028 While rst is high at a clock edge, the block SHALL set state=IDLE, sp=0, last-served=1 (requester 0 wins the first tie), done0=done1=0, err=0 and rdata=0.
REQ-029 Reset in EXEC or RESP SHALL abort the operation with no done pulse; memory contents are undefined after reset.
REQ-030 Outputs after reset SHALL be empty=1, full=0, level=0 and busy=0.

Configuration
REQ-031 Macro STACK_ARB_PEEK_EN SHALL control the peek feature.
REQ-032 With STACK_ARB_PEEK_EN defined, op 10 SHALL behave as peek per REQ-018.
REQ-033 Without STACK_ARB_PEEK_EN, op 10 SHALL be treated as reserved per REQ-023, and no peek logic is present.

Structure
REQ-034 Package stack_pkg SHALL hold the op encoding typedef, the FSM state typedef, and the DEPTH/WIDTH defaults.
REQ-035 Storage SHALL be a sub-module stack_mem (DEPTH x WIDTH, one synchronous write port, one combinational read port at sp-1), instantiated once.

Verification
REQ-036 Reset, then req0 push 0xA5 -> done0 high in cycle 3, err=0, level=1, empty=0.
REQ-037 Push 0x11 then pop by req1 -> done1 with rdata=0x11, err=0, level=0.
REQ-038 req0 and req1 both push (0x01, 0x02) in the same cycle -> req0 served first, req1 next; pops return 0x02 then 0x01.
REQ-039 16 pushes, then a 17th push -> err=1, full=1, level=16; pop of the empty stack after a drain -> err=1, rdata=0.
REQ-040 Push 0x3C then peek (macro on) -> rdata=0x3C, level stays 1; macro off -> err=1.
REQ-041 rst asserted during EXEC of a push -> no done pulse, level=0, busy=0 in the next cycle.
